scalar_mult_seq: RTL and testbench
==================================

# scalar_mult_seq

Sequencing controller for vector-by-scalar multiplication in the feed-forward datapath. It accepts a start request with a scalar and an element count, then streams the source vector out of a synchronous-read neuron buffer. Each element is multiplied by the scalar through a single pipelined multiplier, and each product is written back to a destination buffer. It replaces the fully parallel `MAX_NEURONS`-wide multiplier array with one shared multiplier, and it reports completion to the layer controller with a one-cycle `done` pulse.

## Interface
Parameters:
- `N` — 16 — maximum vector length; matches `MAX_NEURONS`.
- `W` — 32 — element, scalar and product width; two's-complement signed.
- `AW` — `$clog2(N)` — buffer address width.

Ports:
- `clk` — in — 1 — single clock; all state updates on its rising edge.
- `reset` — in — 1 — synchronous, active-high reset.
- `start` — in — 1 — request a run; sampled only in IDLE.
- `scalar` — in — W — multiplier operand; latched when `start` is accepted.
- `len` — in — AW+1 — element count, 0..N; latched when `start` is accepted. Values above N are clamped to N.
- `abort` — in — 1 — terminate the current run.
- `rd_en` — out — 1 — source buffer read strobe.
- `rd_addr` — out — AW — source element index.
- `rd_data` — in — W — source element; valid exactly 1 cycle after `rd_en`.
- `wr_en` — out — 1 — destination buffer write strobe.
- `wr_addr` — out — AW — destination element index.
- `wr_data` — out — W — product.
- `busy` — out — 1 — high from the cycle after acceptance until the last write.
- `done` — out — 1 — one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` high → latch `scalar` and clamped `len`, clear the read counter.
  - Go to RUN, or to DONE if `len`=0.
- RUN:
  - Each cycle: `rd_en`=1, `rd_addr`=counter, counter increments.
  - After issuing address `len`-1 → DRAIN.
- DRAIN: no reads. Stay until the write for index `len`-1 has been issued, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Pipeline (valid bit travels with the index):
  - Stage 1: the read is issued.
  - Stage 2: `rd_data` is captured and multiplied by the latched scalar. The full 2W-bit signed product is computed, and the result is registered.
  - Stage 3: the registered product drives `wr_data`, with `wr_en`=1 and `wr_addr`=index.
- Arithmetic: the default result is the low W bits of the signed product (wrap).
- `start` while not IDLE is ignored. There is no queuing.
- `abort` (any state except IDLE):
  - Next state is IDLE, and all in-flight valid bits are cleared.
  - No further `rd_en`/`wr_en` is issued from the cycle after `abort` is sampled, and no `done` is produced.
  - If `abort` and `start` are both sampled in IDLE, `abort` has no effect and `start` is accepted.
- `reset` (any state): identical effect to `abort`, and additionally applies the reset values.
- Reset values: state IDLE; `rd_en`, `wr_en`, `busy` and `done` = 0; `rd_addr`, `wr_addr` and `wr_data` = 0; counters and latched operands = 0.

## Timing
- Let `start` be accepted at rising edge E0, and let cycle k be the cycle following edge Ek.
- Cycle i (i = 1..len): `rd_en`=1, `rd_addr`=i-1.
- Cycle i+1: `rd_data` holds element i-1.
- Cycle i+2: `wr_en`=1, `wr_addr`=i-1, `wr_data`=product.
- Writes are back-to-back with no bubbles.
- `busy`=1 in cycles 1..len+2.
- `done`=1 in cycle len+3; `busy`=0 in that cycle.
- `len`=0: `done` in cycle 1, with no reads or writes.
- Throughput: one element per cycle. A new `start` can be accepted at the first edge after the `done` cycle, so runs are spaced len+4 cycles apart.
- Outputs are registered. `rd_addr`/`wr_addr`/`wr_data` hold their last value when the corresponding strobe is low.

## Configuration
- Macro: `SCALAR_MULT_SEQ_SAT_EN`.
- Defined: the 2W-bit product is saturated to [-2^(W-1), 2^(W-1)-1] before it is registered. An extra output `sat_flag` (1 bit) is a sticky flag that is set when any element of the current run saturates. It is cleared on `start` acceptance and on reset, and it is valid together with `done`.
- Undefined: the low W bits of the product are used (wrap), and `sat_flag` does not exist.

## Test plan
- Basic run: `len`=4, `scalar`=3, source {1,-2,5,0}.
  - Required: writes {3,-6,15,0} to addresses 0..3 in cycles 3..6, and `done` in cycle 7.
- Full length: `len`=16, `scalar`=-1, source i.
  - Required: 16 consecutive writes of -i.
  - `start` pulsed during the run is ignored, and exactly one `done` is produced.
- Zero and clamp:
  - `len`=0 → `done` in cycle 1 with no `rd_en`/`wr_en`.
  - `len`=20 → exactly 16 writes.
- Abort: `len`=8, `abort` in cycle 4.
  - Required: no `rd_en`/`wr_en` after cycle 4 and no `done`.
  - A `start` in the next cycle runs cleanly from address 0.
- Reset mid-run (cycle 3): every output returns to its reset value in the next cycle.
- Overflow: `scalar`=0x40000000, element 4.
  - Without the macro: `wr_data`=0.
  - With `SCALAR_MULT_SEQ_SAT_EN`: `wr_data`=0x7FFFFFFF, and `sat_flag`=1 at `done`.

Source files
------------

// File: rtl/scalar_mult_seq.sv
// rtl/scalar_mult_seq.sv - vector-by-scalar multiply sequencer with one shared pipelined multiplier (option: SCALAR_MULT_SEQ_SAT_EN)
module scalar_mult_seq #(
    parameter int N  = 16,
    parameter int W  = 32,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  scalar,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_data,
    output logic          busy,
    output logic          done
`ifdef SCALAR_MULT_SEQ_SAT_EN
    ,
    output logic          sat_flag
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(N);

    state_t        state, state_nxt;
    logic [W-1:0]  scalar_q;
    logic [AW:0]   len_q;
    logic [AW:0]   len_m1;
    logic [AW:0]   len_clamp;
    logic [AW:0]   cnt;
    logic          v1;
    logic [AW-1:0] idx1;
    logic          kill;
    logic          last_wr;
    logic [W-1:0]  prod_w;
    logic          sat_hit;

    assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
    assign len_m1    = len_q - {{AW{1'b0}}, 1'b1};
    assign kill      = abort && (state != IDLE);
    assign last_wr   = v1 && ({1'b0, idx1} == len_m1);

`ifdef SCALAR_MULT_SEQ_SAT_EN
    localparam logic signed [2*W-1:0] P_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] P_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    logic signed [2*W-1:0] prod_full;

    // Full-width signed product clamped into the W-bit signed range
    always_comb begin
        prod_full = $signed(rd_data) * $signed(scalar_q);
        sat_hit   = 1'b0;
        prod_w    = prod_full[W-1:0];
        if (prod_full > P_MAX) begin
            prod_w  = {1'b0, {(W-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (prod_full < P_MIN) begin
            prod_w  = {1'b1, {(W-1){1'b0}}};
            sat_hit = 1'b1;
        end
    end
`else
    // Wrapped result: the low W bits of the signed product equal the W-bit modular product
    always_comb begin
        sat_hit = 1'b0;
        prod_w  = rd_data * scalar_q;
    end
`endif

    // Next-state selection; abort from any active state returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len_clamp == '0) ? DONE : RUN;
            RUN:     if (cnt == len_m1) state_nxt = DRAIN;
            DRAIN:   if (last_wr) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    // State register, operand latches, read/multiply/write pipeline and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            scalar_q <= '0;
            len_q    <= '0;
            cnt      <= '0;
            v1       <= 1'b0;
            idx1     <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SCALAR_MULT_SEQ_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                scalar_q <= scalar;
                len_q    <= len_clamp;
                cnt      <= '0;
`ifdef SCALAR_MULT_SEQ_SAT_EN
                sat_flag <= 1'b0;
`endif
            end
            rd_en <= (state == RUN) && !kill;
            if (state == RUN && !kill) begin
                rd_addr <= cnt[AW-1:0];
                cnt     <= cnt + 1'b1;
            end
            v1    <= rd_en && !kill;
            idx1  <= rd_addr;
            wr_en <= v1 && !kill;
            if (v1 && !kill) begin
                wr_addr <= idx1;
                wr_data <= prod_w;
`ifdef SCALAR_MULT_SEQ_SAT_EN
                sat_flag <= sat_flag | sat_hit;
`endif
            end
            busy <= (state == RUN || state == DRAIN) && !kill;
            done <= (state == DONE) && !kill;
        end
    end

`ifndef SCALAR_MULT_SEQ_SAT_EN
    logic unused_sat;
    assign unused_sat = sat_hit;
`endif

endmodule

// File: tb/tb_scalar_mult_seq.sv
// tb/tb_scalar_mult_seq.sv - table-driven bench for scalar_mult_seq (honours SCALAR_MULT_SEQ_SAT_EN)
module tb_scalar_mult_seq;
    localparam int N  = 16;
    localparam int W  = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [W-1:0]  scalar;
    logic [AW:0]   len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          busy, done;
`ifdef SCALAR_MULT_SEQ_SAT_EN
    logic          sat_flag;
`endif

    scalar_mult_seq #(.N(N), .W(W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .scalar(scalar), .len(len),
        .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
`ifdef SCALAR_MULT_SEQ_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read source buffer model
    logic [W-1:0] mem [N];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct packed {
        logic [4:0]        len;
        logic [31:0]       scalar;
        logic [15:0][31:0] src;
        logic [15:0][31:0] exp;
        logic [7:0]        pulse;
        logic              sat;
    } vec_t;

    vec_t vecs[6];
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rd_en"}, 32'(rd_en), 0);
        chk({tag, " wr_en"}, 32'(wr_en), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " rd_addr"}, 32'(rd_addr), 0);
        chk({tag, " wr_addr"}, 32'(wr_addr), 0);
        chk({tag, " wr_data"}, wr_data, 0);
    endtask

    // Starts a run in the current cycle and checks every strobe cycle by cycle until well after done
    task automatic run_vec(input int v);
        int L;
        L = (vecs[v].len > 5'd16) ? 16 : int'(vecs[v].len);
        for (int i = 0; i < N; i++) mem[i] = vecs[v].src[i];
        start  = 1'b1;
        scalar = vecs[v].scalar;
        len    = vecs[v].len;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= L + 6; k++) begin
            logic exp_rd, exp_wr, exp_done, exp_busy;
            @(posedge clk); #1;
            exp_rd   = (k <= L);
            exp_wr   = (L > 0) && (k >= 3) && (k <= L + 2);
            exp_done = (L == 0) ? (k == 1) : (k == L + 3);
            exp_busy = (L > 0) && (k <= L + 2);
            chk($sformatf("v%0d c%0d rd_en", v, k), 32'(rd_en), 32'(exp_rd));
            if (exp_rd) chk($sformatf("v%0d c%0d rd_addr", v, k), 32'(rd_addr), k - 1);
            chk($sformatf("v%0d c%0d wr_en", v, k), 32'(wr_en), 32'(exp_wr));
            if (exp_wr) begin
                chk($sformatf("v%0d c%0d wr_addr", v, k), 32'(wr_addr), k - 3);
                chk($sformatf("v%0d c%0d wr_data", v, k), wr_data, vecs[v].exp[k-3]);
            end
            chk($sformatf("v%0d c%0d done", v, k), 32'(done), 32'(exp_done));
            chk($sformatf("v%0d c%0d busy", v, k), 32'(busy), 32'(exp_busy));
`ifdef SCALAR_MULT_SEQ_SAT_EN
            if (exp_done) chk($sformatf("v%0d sat_flag", v), 32'(sat_flag), 32'(vecs[v].sat));
`endif
            start = (vecs[v].pulse != 0 && k == int'(vecs[v].pulse));
        end
        start = 1'b0;
    endtask

    initial begin
        for (int v = 0; v < 6; v++) vecs[v] = '0;
        // basic run
        vecs[0].len = 4; vecs[0].scalar = 3;
        vecs[0].src[0] = 1; vecs[0].src[1] = -2; vecs[0].src[2] = 5; vecs[0].src[3] = 0;
        vecs[0].exp[0] = 3; vecs[0].exp[1] = -6; vecs[0].exp[2] = 15; vecs[0].exp[3] = 0;
        // full length, negation, spurious start mid-run
        vecs[1].len = 16; vecs[1].scalar = -1; vecs[1].pulse = 5;
        for (int i = 0; i < 16; i++) begin vecs[1].src[i] = i; vecs[1].exp[i] = -i; end
        // zero length
        vecs[2].len = 0; vecs[2].scalar = 9;
        // clamp 20 -> 16
        vecs[3].len = 20; vecs[3].scalar = 2;
        for (int i = 0; i < 16; i++) begin vecs[3].src[i] = i; vecs[3].exp[i] = 2 * i; end
        // overflow
        vecs[4].len = 1; vecs[4].scalar = 32'h4000_0000; vecs[4].src[0] = 4; vecs[4].sat = 1'b1;
`ifdef SCALAR_MULT_SEQ_SAT_EN
        vecs[4].exp[0] = 32'h7FFF_FFFF;
`else
        vecs[4].exp[0] = 32'h0000_0000;
`endif
        // mixed signs
        vecs[5].len = 3; vecs[5].scalar = -7;
        vecs[5].src[0] = -3; vecs[5].src[1] = 100; vecs[5].src[2] = 32767;
        vecs[5].exp[0] = 21; vecs[5].exp[1] = -700; vecs[5].exp[2] = -229369;

        reset = 1'b1; start = 1'b0; abort = 1'b0; scalar = '0; len = '0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
`ifdef SCALAR_MULT_SEQ_SAT_EN
        chk("reset sat_flag", 32'(sat_flag), 0);
`endif
        reset = 1'b0;

        for (int v = 0; v < 6; v++) run_vec(v);

        // abort in cycle 4 of an 8-element run, then an immediate clean restart
        for (int i = 0; i < N; i++) mem[i] = i;
        start = 1'b1; scalar = 3; len = 8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort c%0d rd_en", k), 32'(rd_en), 1);
            chk($sformatf("abort c%0d rd_addr", k), 32'(rd_addr), k - 1);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort c5 rd_en", 32'(rd_en), 0);
        chk("abort c5 wr_en", 32'(wr_en), 0);
        chk("abort c5 done", 32'(done), 0);
        chk("abort c5 busy", 32'(busy), 0);
        run_vec(5);

        // reset asserted in cycle 3 of a run
        for (int i = 0; i < N; i++) mem[i] = i + 10;
        start = 1'b1; scalar = 3; len = 8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst c3 wr_en", 32'(wr_en), 1);
        chk("rst c3 wr_data", wr_data, 30);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("rst c4");
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post-reset rd_en", 32'(rd_en), 0);
            chk("post-reset done", 32'(done), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
